// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: alternating-priority grant, fixed three-cycle transaction
// (IDLE -> ACCESS -> RESP) with out-of-range address detection.
module dmem_arbiter #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic        id_q, id_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        win;
  logic [31:0] win_addr;
  logic        in_access, in_resp, mem_en;

  // Ties go to the port that did not win last time; a lone requester always wins.
  assign win      = (req0 & req1) ? ~last_q : req1;
  assign win_addr = win ? addr1 : addr0;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    id_d     = id_q;
    we_d     = we_q;
    err_d    = err_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      StIdle: begin
        if (req0 | req1) begin
          state_d = StAccess;
          last_d  = win;
          id_d    = win;
          we_d    = win ? we1 : we0;
          addr_d  = win_addr;
          wdata_d = win ? wdata1 : wdata0;
          err_d   = win_addr >= 32'(DEPTH);
        end
      end
      StAccess: begin
        state_d = StResp;
        // Capture straight into the port's holding register; writes and errors return 0.
        if (id_q) rdata1_d = (we_q | err_q) ? 32'h0 : mem_rdata;
        else      rdata0_d = (we_q | err_q) ? 32'h0 : mem_rdata;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      last_q   <= 1'b1;
      id_q     <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rdata0_q <= 32'h0;
      rdata1_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      id_q     <= id_d;
      we_q     <= we_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Outputs decode from state, so an asynchronous reset clears them without a clock edge.
  assign in_access = (state_q == StAccess);
  assign in_resp   = (state_q == StResp);
  assign mem_en    = in_access & ~err_q;

  assign gnt0      = in_access & ~id_q;
  assign gnt1      = in_access & id_q;
  assign rvalid0   = in_resp & ~id_q;
  assign rvalid1   = in_resp & id_q;
  assign err0      = in_resp & ~id_q & err_q;
  assign err1      = in_resp & id_q & err_q;
  assign mem_read  = mem_en & ~we_q;
  assign mem_write = mem_en & we_q;
  assign mem_addr  = mem_en ? addr_q : 32'h0;
  assign mem_wdata = mem_en ? wdata_q : 32'h0;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a transaction-level model (winner choice, shadow
// memory, per-port held read data) predicts every cycle of each three-cycle transaction.
module tb_dmem_arbiter;

  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_read, mem_write;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic        mem_clr = 1'b0;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          last_w;
  logic [31:0] rd_exp0, rd_exp1;

  always #5 clk = ~clk;

  dmem_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .err0(err0), .err1(err1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Simple synchronous-write, combinational-read memory behind the arbiter.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= 32'h0;
    end else if (mem_write && mem_addr < DEPTH) begin
      mem[mem_addr[9:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = (mem_addr < DEPTH) ? mem[mem_addr[9:0]] : 32'h0;

  function automatic logic [7:0] flags();
    return {gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_read, mem_write};
  endfunction

  // One full transaction starting at a negedge in IDLE with both reqs low.
  task automatic txn(input logic r0, input logic r1, input logic w0, input logic w1,
                     input logic [31:0] a0, input logic [31:0] a1,
                     input logic [31:0] d0, input logic [31:0] d1, input string tag);
    int          win;
    logic        w_we, inr;
    logic [31:0] w_a, w_d, exp_rd;
    logic [7:0]  exp_f;
    win    = (r0 && r1) ? (last_w == 1 ? 0 : 1) : (r0 ? 0 : 1);
    last_w = win;
    w_we   = (win == 1) ? w1 : w0;
    w_a    = (win == 1) ? a1 : a0;
    w_d    = (win == 1) ? d1 : d0;
    inr    = (w_a < DEPTH);
    exp_rd = (inr && !w_we) ? ref_mem[w_a[9:0]] : 32'h0;
    req0 = r0; req1 = r1; we0 = w0; we1 = w1;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    @(posedge clk); @(negedge clk);
    exp_f = {win == 0, win == 1, 4'b0000, inr & ~w_we, inr & w_we};
    n_cmp++;
    if (flags() !== exp_f) begin
      n_bad++; $display("FAIL %s access_flags: got %b want %b", tag, flags(), exp_f);
    end
    if (inr) begin
      n_cmp++;
      if (mem_addr !== w_a) begin
        n_bad++; $display("FAIL %s mem_addr: got %h want %h", tag, mem_addr, w_a);
      end
    end
    if (inr && w_we) begin
      n_cmp++;
      if (mem_wdata !== w_d) begin
        n_bad++; $display("FAIL %s mem_wdata: got %h want %h", tag, mem_wdata, w_d);
      end
      ref_mem[w_a[9:0]] = w_d;
    end
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); @(negedge clk);
    exp_f = {2'b00, win == 0, win == 1, (win == 0) & ~inr, (win == 1) & ~inr, 2'b00};
    if (win == 0) rd_exp0 = exp_rd; else rd_exp1 = exp_rd;
    n_cmp++;
    if (flags() !== exp_f) begin
      n_bad++; $display("FAIL %s resp_flags: got %b want %b", tag, flags(), exp_f);
    end
    n_cmp++;
    if ({rdata0, rdata1} !== {rd_exp0, rd_exp1}) begin
      n_bad++;
      $display("FAIL %s resp_rdata: got %h/%h want %h/%h", tag, rdata0, rdata1, rd_exp0, rd_exp1);
    end
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if ({flags(), rdata0, rdata1} !== {8'h00, rd_exp0, rd_exp1}) begin
      n_bad++;
      $display("FAIL %s idle_hold: got %b %h/%h want 0 %h/%h", tag, flags(), rdata0, rdata1,
               rd_exp0, rd_exp1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_clr = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = 32'h0;
    last_w = 1; rd_exp0 = '0; rd_exp1 = '0;
    repeat (2) @(negedge clk);
    mem_clr = 1'b0;
    n_cmp++;
    if ({flags(), rdata0, rdata1, mem_addr, mem_wdata} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got %b rdata %h/%h want all 0", flags(), rdata0, rdata1);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (flags() !== 8'h00) begin
      n_bad++; $display("FAIL idle_no_req: got %b want 00000000", flags());
    end
  endtask

  task automatic test_single_read();
    txn(1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 32'd5, 32'd0, 32'hDEADBEEF, "preload");
    txn(1'b1, 1'b0, 1'b0, 1'b0, 32'd5, 32'd0, 32'd0, 32'd0, "single_read");
    n_cmp++;
    if (rdata0 !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL single_read_data: got %h want deadbeef", rdata0);
    end
  endtask

  task automatic test_tie_alternation();
    logic [1:0] exp_g;
    rst_n = 1'b0;
    @(negedge clk);
    last_w = 1; rd_exp0 = '0; rd_exp1 = '0;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = 32'd2000; addr1 = 32'd3000;
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      exp_g = (c % 3 == 1) ? (((c / 3) % 2 == 0) ? 2'b10 : 2'b01) : 2'b00;
      n_cmp++;
      if ({gnt0, gnt1} !== exp_g) begin
        n_bad++; $display("FAIL tie_cycle%0d: got %b want %b", c, {gnt0, gnt1}, exp_g);
      end
      if (c == 11) begin req0 = 1'b0; req1 = 1'b0; end
      @(posedge clk); @(negedge clk);
    end
    last_w = 1;
  endtask

  task automatic test_write_then_read();
    txn(1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 32'd7, 32'd0, 32'h12345678, "wr7");
    n_cmp++;
    if (rdata1 !== 32'h0) begin
      n_bad++; $display("FAIL write_rdata1: got %h want 0", rdata1);
    end
    txn(1'b1, 1'b0, 1'b0, 1'b0, 32'd7, 32'd0, 32'd0, 32'd0, "rd7");
    n_cmp++;
    if (rdata0 !== 32'h12345678) begin
      n_bad++; $display("FAIL read_after_write: got %h want 12345678", rdata0);
    end
  endtask

  task automatic test_out_of_range();
    txn(1'b1, 1'b0, 1'b1, 1'b0, 32'd1024, 32'd0, 32'hCAFEF00D, 32'd0, "oor_w1024");
    txn(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, "oor_rFFFFFFFF");
    txn(1'b1, 1'b0, 1'b0, 1'b0, 32'd1023, 32'd0, 32'd0, 32'd0, "edge_r1023");
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] old3;
    txn(1'b1, 1'b0, 1'b1, 1'b0, 32'd3, 32'd0, 32'h5A5A0003, 32'd0, "seed3");
    old3 = ref_mem[3];
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd3; wdata0 = ~old3; req1 = 1'b0;
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if ({gnt0, mem_write} !== 2'b11) begin
      n_bad++; $display("FAIL rst_pre_access: got %b want 11", {gnt0, mem_write});
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({flags(), rdata0, rdata1, mem_addr, mem_wdata} !== '0) begin
      n_bad++; $display("FAIL rst_async_outputs: got %b rdata %h/%h want all 0", flags(), rdata0,
                        rdata1);
    end
    req0 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if ({rvalid0, rvalid1} !== 2'b00) begin
        n_bad++; $display("FAIL rst_no_rvalid%0d: got %b want 00", c, {rvalid0, rvalid1});
      end
    end
    n_cmp++;
    if (mem[3] !== old3) begin
      n_bad++; $display("FAIL rst_word3: got %h want %h", mem[3], old3);
    end
    rst_n = 1'b1; last_w = 1; rd_exp0 = '0; rd_exp1 = '0;
    @(negedge clk);
    txn(1'b1, 1'b1, 1'b0, 1'b0, 32'd3, 32'd5, 32'd0, 32'd0, "post_rst_tie");
  endtask

  task automatic test_random();
    logic        r0, r1, w0, w1;
    logic [31:0] a [2];
    for (int n = 0; n < 60; n++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) r0 = 1'b1;
      w0 = 1'($urandom_range(0, 1));
      w1 = 1'($urandom_range(0, 1));
      for (int p = 0; p < 2; p++) begin
        if ($urandom_range(0, 7) == 0) begin
          case ($urandom_range(0, 2))
            0:       a[p] = 32'd1024;
            1:       a[p] = 32'hFFFF_FFFF;
            default: a[p] = 32'h0001_0000 + $urandom_range(0, 99);
          endcase
        end else begin
          a[p] = $urandom_range(0, 15);
        end
      end
      txn(r0, r1, w0, w1, a[0], a[1], $urandom, $urandom, "random");
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if (flags() !== 8'h00) begin
          n_bad++; $display("FAIL random_gap: got %b want 00000000", flags());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_then_read();
    test_out_of_range();
    test_random();
    test_reset_mid_op();
    test_tie_alternation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
